rv32i_dmem: RTL and testbench

Data-memory responder for the single-cycle RV32I core: the slave end of the core's data-memory interface. Stores complete on the clock edge with byte-lane masking. Loads return data combinationally in the same cycle, with byte/halfword extraction and sign or zero extension. A small MMIO window provides a test-completion mailbox (`tohost`), a free-running cycle counter and a misaligned-store counter for simulation and bring-up.

---
 rtl/rv32i_dmem.sv | 126 ++++++++++++
 tb/tb_rv32i_dmem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem.sv
// rv32i_dmem: data-memory slave for the single-cycle RV32I core.
// Byte-lane masked stores land on the rising clock edge. Loads are purely
// combinational with byte/half extraction and sign or zero extension. A small
// MMIO window holds the tohost mailbox, a cycle counter and a misaligned-store
// counter.
module rv32i_dmem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  MemSize,
  output logic [31:0] ReadData,
  output logic        done,
  output logic [31:0] tohost,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // funct3 encodings of the load/store size field
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_mmio;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          misaligned;
  logic          ram_we;
  logic          tohost_we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   cycle;
  logic [31:0]   misalign_cnt;
  logic [31:0]   mmio_word;
  logic [31:0]   word;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  assign idx     = ALUResult[AW+1:2];
  assign lane    = ALUResult[1:0];
  assign is_mmio = (ALUResult[31:12] == MMIO_BASE[31:12]);

  // Decode the store: size class, alignment, lane enables and replicated data.
  // Undefined size encodings fall into no class, so they neither write nor count.
  always_comb begin
    is_byte    = (MemSize == SZ_B) || (MemSize == SZ_BU);
    is_half    = (MemSize == SZ_H) || (MemSize == SZ_HU);
    is_word    = (MemSize == SZ_W);
    misaligned = MemWrite && ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
    be         = 4'b0000;
    wdata      = WriteData;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{WriteData[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteData[15:0]}};
    end else if (is_word) begin
      be    = 4'b1111;
    end
    ram_we    = MemWrite && !rst && !is_mmio && !misaligned && (be != 4'b0000);
    tohost_we = MemWrite && is_mmio && is_word && (ALUResult[11:0] == 12'h000);
  end

  // RAM byte-lane write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // MMIO state and sticky flags, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost       <= 32'h0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      cycle        <= 32'h0;
      misalign_cnt <= 32'h0;
    end else begin
      cycle <= cycle + 32'h1;
      if (tohost_we) begin
        tohost <= WriteData;
        done   <= 1'b1;
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
        if (misalign_cnt != 32'hFFFF_FFFF) misalign_cnt <= misalign_cnt + 32'h1;
      end
    end
  end

  // Load path: pick the word, then extract the lane and extend.
  always_comb begin
    case (ALUResult[11:2])
      10'd0:   mmio_word = tohost;
      10'd1:   mmio_word = cycle;
      10'd2:   mmio_word = misalign_cnt;
      default: mmio_word = 32'h0;
    endcase
    word  = is_mmio ? mmio_word : mem[idx];
    rbyte = word[8*lane +: 8];
    rhalf = lane[1] ? word[31:16] : word[15:0];
    case (MemSize)
      SZ_B:    ReadData = {{24{rbyte[7]}}, rbyte};
      SZ_BU:   ReadData = {24'h0, rbyte};
      SZ_H:    ReadData = {{16{rhalf[15]}}, rhalf};
      SZ_HU:   ReadData = {16'h0, rhalf};
      default: ReadData = word;
    endcase
  end

endmodule

// File: tb/tb_rv32i_dmem.sv
// tb_rv32i_dmem: table-driven directed bench for rv32i_dmem plus hand-written
// sequences for the mailbox, sticky flags, cycle counter and mid-run reset.
module tb_rv32i_dmem;

  localparam logic [31:0] MB   = 32'h8000_0000;
  localparam logic [2:0]  S_B  = 3'b000;
  localparam logic [2:0]  S_H  = 3'b001;
  localparam logic [2:0]  S_W  = 3'b010;
  localparam logic [2:0]  S_BU = 3'b100;
  localparam logic [2:0]  S_HU = 3'b101;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [2:0]  MemSize;
  logic [31:0] ReadData;
  logic        done;
  logic [31:0] tohost;
  logic        misalign_err;

  int   errors;
  int   checks;
  vec_t vecs[$];

  rv32i_dmem #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk(clk),
    .rst(rst),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .MemSize(MemSize),
    .ReadData(ReadData),
    .done(done),
    .tohost(tohost),
    .misalign_err(misalign_err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs and let the combinational load path settle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [2:0] size);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    MemSize   = size;
    #2;
  endtask

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main test sequence.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; MemSize = S_W;

    vecs.push_back('{1'b1, 32'h10,   32'h11223344, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        S_W,    1'b1, 32'h11223344});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        S_B,    1'b1, 32'h00000044});
    vecs.push_back('{1'b0, 32'h11,   32'h0,        S_BU,   1'b1, 32'h00000033});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        S_B,    1'b1, 32'h00000011});
    vecs.push_back('{1'b0, 32'h12,   32'h0,        S_H,    1'b1, 32'h00001122});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        S_HU,   1'b1, 32'h00003344});
    vecs.push_back('{1'b0, 32'h1010, 32'h0,        S_W,    1'b1, 32'h11223344});
    vecs.push_back('{1'b1, 32'h20,   32'hFFFF8080, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        S_B,    1'b1, 32'hFFFFFF80});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        S_BU,   1'b1, 32'h00000080});
    vecs.push_back('{1'b0, 32'h22,   32'h0,        S_H,    1'b1, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        S_HU,   1'b1, 32'h00008080});
    vecs.push_back('{1'b0, 32'h23,   32'h0,        S_BU,   1'b1, 32'h000000FF});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        3'b111, 1'b1, 32'hFFFF8080});
    vecs.push_back('{1'b1, 32'h20,   32'h0,        S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h21,   32'h123456AB, S_B,    1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        S_W,    1'b1, 32'h0000AB00});
    vecs.push_back('{1'b1, 32'h22,   32'hFFFFBEEF, S_HU,   1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        S_W,    1'b1, 32'hBEEFAB00});
    vecs.push_back('{1'b1, 32'h30,   32'hAAAA5555, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h40,   32'h0,        S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h31,   32'h00001234, S_H,    1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h42,   32'hDEADBEEF, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h30,   32'h0,        S_W,    1'b1, 32'hAAAA5555});
    vecs.push_back('{1'b0, 32'h40,   32'h0,        S_W,    1'b1, 32'h00000000});
    vecs.push_back('{1'b0, MB + 8,   32'h0,        S_W,    1'b1, 32'h00000002});
    vecs.push_back('{1'b1, 32'h30,   32'hFFFFFFFF, 3'b011, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h30,   32'h0,        S_W,    1'b1, 32'hAAAA5555});
    vecs.push_back('{1'b0, MB + 8,   32'h0,        S_W,    1'b1, 32'h00000002});
    vecs.push_back('{1'b1, 32'h50,   32'h00000099, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h50,   32'h00000055, S_W,    1'b1, 32'h00000099});
    vecs.push_back('{1'b0, 32'h50,   32'h0,        S_W,    1'b1, 32'h00000055});
    vecs.push_back('{1'b1, MB + 12,  32'hFFFFFFFF, S_W,    1'b0, 32'h0});
    vecs.push_back('{1'b0, MB + 12,  32'h0,        S_W,    1'b1, 32'h00000000});
    vecs.push_back('{1'b0, MB + 8,   32'h0,        S_B,    1'b1, 32'h00000002});
    vecs.push_back('{1'b1, 32'h33,   32'h000000EE, S_BU,   1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h30,   32'h0,        S_W,    1'b1, 32'hEEAA5555});
    vecs.push_back('{1'b0, 32'h32,   32'h0,        S_H,    1'b1, 32'hFFFFEEAA});

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, MB + 8, 32'h0, S_W);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_tohost", tohost, 32'h0);
    checkOutput("reset_misalign_err", {31'h0, misalign_err}, 32'h0);
    checkOutput("reset_misalign_cnt", ReadData, 32'h0);
    @(negedge clk);

    // Table-driven vectors, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), ReadData, vecs[i].exp);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, S_W);
    checkOutput("misalign_err_set", {31'h0, misalign_err}, 32'h1);
    @(negedge clk);

    // tohost mailbox: byte/half stores ignored, word store sets done
    applyStimulus(1'b1, MB, 32'h5, S_B);
    @(negedge clk);
    applyStimulus(1'b1, MB, 32'h1, S_H);
    checkOutput("done_after_sb", {31'h0, done}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, MB, 32'h1, S_W);
    checkOutput("done_before_sw", {31'h0, done}, 32'h0);
    checkOutput("tohost_before_sw", tohost, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, MB, 32'h0, S_W);
    checkOutput("done_after_sw", {31'h0, done}, 32'h1);
    checkOutput("tohost_after_sw", tohost, 32'h1);
    checkOutput("tohost_read", ReadData, 32'h1);
    @(negedge clk);
    applyStimulus(1'b1, MB, 32'hA5A50007, S_W);
    @(negedge clk);
    applyStimulus(1'b0, MB + 2, 32'h0, S_B);
    checkOutput("done_sticky", {31'h0, done}, 32'h1);
    checkOutput("tohost_update", tohost, 32'hA5A50007);
    checkOutput("tohost_lb", ReadData, 32'hFFFFFFA5);

    // Reset asserted between edges clears state at once and blocks RAM writes
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b0, MB + 4, 32'h0, S_W);
    checkOutput("midrst_cycle", ReadData, 32'h0);
    checkOutput("midrst_done", {31'h0, done}, 32'h0);
    checkOutput("midrst_tohost", tohost, 32'h0);
    checkOutput("midrst_misalign_err", {31'h0, misalign_err}, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, S_W);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, MB + 4, 32'h0, S_W);
    checkOutput("cycle_first", ReadData, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, MB + 4, 32'h0, S_W);
    checkOutput("cycle_second", ReadData, 32'h1);
    applyStimulus(1'b0, 32'h10, 32'h0, S_W);
    checkOutput("ram_retained", ReadData, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
